// File: rtl/gb_oam_dma_if.sv
// OAM DMA bus bundle: source read side and OAM write side.
// master = DMA controller, slave = bus/OAM side.
//   adr_rd   DMA source address      read     source read strobe
//   data_in  byte from source        adr_wr   OAM destination offset
//   write    OAM write strobe        data_out byte to OAM
//   active   transfer in progress (steers OAM mux, blanks CPU reads)
interface gb_oam_dma_if;
    logic [15:0] adr_rd;
    logic        read;
    logic [7:0]  data_in;
    logic [7:0]  adr_wr;
    logic        write;
    logic [7:0]  data_out;
    logic        active;

    modport master (
        output adr_rd, read, adr_wr, write, data_out, active,
        input  data_in
    );

    modport slave (
        input  adr_rd, read, adr_wr, write, data_out, active,
        output data_in
    );
endinterface

// File: rtl/gb_oam_dma.sv
// OAM DMA controller (0xFF46): copies LENGTH bytes from page P to OAM.
// Ports: clk, reset (async high), write_reg/din/dout CPU register,
//   bus (gb_oam_dma_if.master) carrying read/write/active strobes.
module gb_oam_dma #(
    parameter int LENGTH          = 160,
    parameter int CYCLES_PER_BYTE = 4,
    parameter int START_DELAY     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_reg,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    gb_oam_dma_if.master bus
);
    localparam int PW = $clog2(CYCLES_PER_BYTE);
    localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

    localparam logic [DW-1:0] DLY_INIT = DW'(START_DELAY - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(CYCLES_PER_BYTE - 1);
    localparam logic [PW-1:0] PH_WR    = PW'(2);
    localparam logic [7:0]    IDX_LAST = 8'(LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        XFER
    } state_t;

    state_t        state, state_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic [PW-1:0] ph, ph_n;
    logic [7:0]    idx, idx_n;
    logic [7:0]    src, src_n;
    logic [7:0]    page_map;

    logic [15:0]   adr_rd_q;
    logic          read_q;
    logic [7:0]    adr_wr_q;
    logic          write_q;
    logic [7:0]    data_q;
    logic          active_q;
    logic          active_n;

    // Echo RAM pages fold back onto work RAM.
    assign page_map = (din >= 8'hE0) ? din - 8'h20 : din;

    always_comb begin
        state_n = state;
        dcnt_n  = dcnt;
        ph_n    = ph;
        idx_n   = idx;
        src_n   = src;
        if (write_reg) begin
            state_n = DELAY;
            dcnt_n  = DLY_INIT;
            ph_n    = '0;
            idx_n   = '0;
            src_n   = page_map;
        end else begin
            unique case (state)
                IDLE: ;
                DELAY: begin
                    if (dcnt == '0) begin
                        state_n = XFER;
                        ph_n    = '0;
                    end else begin
                        dcnt_n = dcnt - 1'b1;
                    end
                end
                XFER: begin
                    if (ph == PH_LAST) begin
                        ph_n = '0;
                        if (idx == IDX_LAST) begin
                            state_n = IDLE;
                        end else begin
                            idx_n = idx + 8'd1;
                        end
                    end else begin
                        ph_n = ph + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        // A restart delay inherits busy so the flag never gaps.
        active_n = (state_n == XFER) ||
                   ((state_n == DELAY) &&
                    ((state == XFER) ||
                     ((state == DELAY) && active_q)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            dcnt  <= '0;
            ph    <= '0;
            idx   <= '0;
            src   <= '0;
        end else begin
            state <= state_n;
            dcnt  <= dcnt_n;
            ph    <= ph_n;
            idx   <= idx_n;
            src   <= src_n;
        end
    end

    // Strobes are registered from next-state so they line up with phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout     <= 8'hFF;
            adr_rd_q <= 16'h0000;
            read_q   <= 1'b0;
            adr_wr_q <= 8'h00;
            write_q  <= 1'b0;
            data_q   <= 8'h00;
            active_q <= 1'b0;
        end else begin
            if (write_reg) begin
                dout <= din;
            end
            adr_rd_q <= {src_n, idx_n};
            read_q   <= (state_n == XFER) && (ph_n < PH_WR);
            adr_wr_q <= idx_n;
            write_q  <= (state_n == XFER) && (ph_n == PH_WR);
            active_q <= active_n;
            if ((state == XFER) && (ph == PW'(1))) begin
                data_q <= bus.data_in;
            end
        end
    end

    assign bus.adr_rd   = adr_rd_q;
    assign bus.read     = read_q;
    assign bus.adr_wr   = adr_wr_q;
    assign bus.write    = write_q;
    assign bus.data_out = data_q;
    assign bus.active   = active_q;
endmodule
